// File: rtl/progobj_cfg_loader_if.sv
// Host/chain signal bundle for the LUT4 configuration loader.
//   start, abort         : frame control from the pin wrapper
//   byte_in/valid/ready  : configuration byte handshake
//   cfg_en/dout/din      : serial config chain (head out, tail in)
//   cfg_latch            : one-cycle commit pulse to LUT storage
//   rb_byte              : last 8 bits seen at the chain tail
//   busy, done           : status
// master = pin wrapper / testbench side, slave = loader.
interface progobj_cfg_loader_if;
  logic       start;
  logic       abort;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       cfg_en;
  logic       cfg_dout;
  logic       cfg_din;
  logic       cfg_latch;
  logic [7:0] rb_byte;
  logic       busy;
  logic       done;

  modport master (
    output start, abort, byte_in, byte_valid, cfg_din,
    input  byte_ready, cfg_en, cfg_dout, cfg_latch, rb_byte, busy, done
  );

  modport slave (
    input  start, abort, byte_in, byte_valid, cfg_din,
    output byte_ready, cfg_en, cfg_dout, cfg_latch, rb_byte, busy, done
  );
endinterface

// File: rtl/progobj_cfg_loader.sv
// Configuration loader for the programmable LUT4 tile.
// Accepts bytes over a valid/ready handshake, shifts each one MSB-first into
// the config chain (8 cycles of cfg_en per byte), captures the chain tail into
// rb_byte, and pulses cfg_latch once CHAIN_LEN bits have been shifted.
// Ports: clk, rst_n (async, active low), bus (progobj_cfg_loader_if.slave).
// Every output is decoded from registered state only.
module progobj_cfg_loader #(
  parameter int CHAIN_LEN = 64  // multiple of 8, 8..1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  progobj_cfg_loader_if.slave   bus
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] FRAME_BITS = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] BYTE_BITS  = CW'(8);

  typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, LATCH} state_t;

  state_t        state, state_nxt;
  logic [7:0]    sr;
  logic [7:0]    rb_sr;
  logic [7:0]    rb_byte_q;
  logic [2:0]    bit_idx;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] frame_cnt_nxt;
  logic          done_q;
  logic          last_bit;

  assign last_bit      = (bit_idx == 3'd7);
  assign frame_cnt_nxt = frame_cnt + BYTE_BITS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.start) state_nxt = WAIT_BYTE;
      WAIT_BYTE: if (bus.byte_valid) state_nxt = SHIFT;
      SHIFT:     if (last_bit)
                   state_nxt = (frame_cnt_nxt == FRAME_BITS) ? LATCH : WAIT_BYTE;
      LATCH:     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    // abort overrides everything, including a start seen in IDLE
    if (bus.abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      rb_sr     <= '0;
      rb_byte_q <= '0;
      bit_idx   <= '0;
      frame_cnt <= '0;
      done_q    <= 1'b0;
    end else if (bus.abort) begin
      // rb_byte is deliberately preserved so a partial readback stays visible
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          frame_cnt <= '0;
          done_q    <= 1'b0;
        end
        WAIT_BYTE: if (bus.byte_valid) begin
          sr      <= bus.byte_in;
          bit_idx <= '0;
        end
        SHIFT: begin
          sr      <= {sr[6:0], 1'b0};
          rb_sr   <= {rb_sr[6:0], bus.cfg_din};
          bit_idx <= bit_idx + 3'd1;
          if (last_bit) begin
            // include this cycle's tail bit so the first sampled bit ends in bit 7
            rb_byte_q <= {rb_sr[6:0], bus.cfg_din};
            frame_cnt <= frame_cnt_nxt;
          end
        end
        LATCH: done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = (state == WAIT_BYTE);
  assign bus.cfg_en     = (state == SHIFT);
  assign bus.cfg_dout   = (state == SHIFT) & sr[7];
  assign bus.cfg_latch  = (state == LATCH);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.rb_byte    = rb_byte_q;
endmodule
